// File: rtl/bscan_pkg.sv
// Shared types and width helpers for the BSCANE2 user-register bridge.
// BSCAN_STATUS_BITS_EN widens the register by two flag bits shifted out after the data.
package bscan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        SHIFT,
        UPD
    } state_t;

`ifdef BSCAN_STATUS_BITS_EN
    localparam int unsigned STATUS_W = 2;
`else
    localparam int unsigned STATUS_W = 0;
`endif

    // REG_W: shifted register width for a given data width.
    function automatic int unsigned reg_w(input int unsigned dw);
        return dw + STATUS_W;
    endfunction

    // Bit counter must hold 0..REG_W+1 (saturation point).
    function automatic int unsigned cnt_w(input int unsigned dw);
        return $clog2(reg_w(dw) + 2);
    endfunction

endpackage

// File: rtl/bscan_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses of the synchronized level.
module bscan_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
            prev <= pipe[STAGES-1];
            rise <= pipe[STAGES-1] & ~prev;
            fall <= ~pipe[STAGES-1] & prev;
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/bscan_user_bridge.sv
// Fabric-side BSCANE2 user data register: oversampled JTAG, capture/shift/update, valid/ready handoff.
// BSCAN_STATUS_BITS_EN appends {len_err, overrun} above the captured word.
module bscan_user_bridge
    import bscan_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          bs_tck,
    input  logic          bs_tdi,
    input  logic          bs_sel,
    input  logic          bs_shift,
    input  logic          bs_capture,
    input  logic          bs_update,
    input  logic          bs_reset,
    output logic          bs_tdo,
    input  logic [DW-1:0] cap_data,
    output logic [DW-1:0] upd_data,
    output logic          upd_valid,
    input  logic          upd_ready,
    output logic          overrun,
    output logic          len_err,
    input  logic          clr_flags
);

    localparam int unsigned REG_W  = reg_w(DW);
    localparam int unsigned CNT_W  = cnt_w(DW);
    localparam int unsigned NPLAIN = 5;

    logic [NPLAIN-1:0] pipe [SYNC_STAGES];
    logic              rst_s, cap_s, shf_s, sel_s, tdi_s;
    logic              tck_s, tck_r, tck_f;
    logic              upd_s, upd_r, upd_f;
    logic              upd_evt;
    logic              unused_sync;

    state_t            state;
    logic [REG_W-1:0]  sr;
    logic [REG_W-1:0]  cap_word;
    logic [CNT_W-1:0]  cnt;

    // Level-only inputs share the TCK synchronizer depth so TDI stays aligned with its edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {bs_reset, bs_capture, bs_shift, bs_sel, bs_tdi};
            for (int i = 1; i < int'(SYNC_STAGES); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {rst_s, cap_s, shf_s, sel_s, tdi_s} = pipe[SYNC_STAGES-1];

    bscan_sync_edge #(.STAGES(SYNC_STAGES)) u_tck_sync (
        .clk  (CLK),
        .rst  (RST),
        .d    (bs_tck),
        .q    (tck_s),
        .rise (tck_r),
        .fall (tck_f)
    );

    bscan_sync_edge #(.STAGES(SYNC_STAGES)) u_upd_sync (
        .clk  (CLK),
        .rst  (RST),
        .d    (bs_update),
        .q    (upd_s),
        .rise (upd_r),
        .fall (upd_f)
    );

    assign unused_sync = ^{tck_s, upd_s, upd_f};
    assign upd_evt     = upd_r & sel_s & ~rst_s;

`ifdef BSCAN_STATUS_BITS_EN
    assign cap_word = {len_err, overrun, cap_data};
`else
    assign cap_word = cap_data;
`endif

    // TAP-following FSM; everything freezes while SEL is low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (rst_s) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (sel_s) begin
            if (upd_evt) begin
                state <= UPD;
            end else if (tck_r) begin
                if (cap_s) begin
                    state <= CAPT;
                    sr    <= cap_word;
                    cnt   <= '0;
                end else if (shf_s && (state == CAPT || state == SHIFT)) begin
                    state <= SHIFT;
                    sr    <= {tdi_s, sr[REG_W-1:1]};
                    if (cnt != CNT_W'(REG_W + 1)) cnt <= cnt + CNT_W'(1);
                end else if (state == SHIFT || state == UPD) begin
                    state <= IDLE;
                end
            end else if (state == UPD) begin
                state <= IDLE;
            end
        end
    end

    // TDO, update handoff and sticky flags; an update meeting acceptance in the same cycle is free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bs_tdo    <= 1'b0;
            upd_data  <= '0;
            upd_valid <= 1'b0;
            overrun   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (tck_f && sel_s) bs_tdo <= sr[0];

            if (upd_evt && (!upd_valid || upd_ready)) begin
                upd_data  <= sr[DW-1:0];
                upd_valid <= 1'b1;
            end else if (upd_valid && upd_ready) begin
                upd_valid <= 1'b0;
            end

            if (upd_evt && upd_valid && !upd_ready) overrun <= 1'b1;
            else if (clr_flags)                      overrun <= 1'b0;

            if (upd_evt)        len_err <= (cnt != CNT_W'(REG_W));
            else if (clr_flags) len_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bscan_user_bridge.sv
// Directed + randomized bench for bscan_user_bridge against a word-level model of the user DR.
module tb_bscan_user_bridge;

    localparam int unsigned DW = 32;
`ifdef BSCAN_STATUS_BITS_EN
    localparam int RW     = 34;
    localparam bit STATUS = 1'b1;
`else
    localparam int RW     = 32;
    localparam bit STATUS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          bs_tck, bs_tdi, bs_sel, bs_shift, bs_capture, bs_update, bs_reset;
    logic          bs_tdo;
    logic [DW-1:0] cap_data;
    logic [DW-1:0] upd_data;
    logic          upd_valid, upd_ready, overrun, len_err, clr_flags;

    int vectors    = 0;
    int miscompares = 0;

    // Model of what the fabric should see.
    logic [31:0] m_data;
    logic        m_valid, m_ovr, m_len;

    bscan_user_bridge #(.DW(DW), .SYNC_STAGES(2)) dut (
        .CLK        (clk),
        .RST        (rst),
        .bs_tck     (bs_tck),
        .bs_tdi     (bs_tdi),
        .bs_sel     (bs_sel),
        .bs_shift   (bs_shift),
        .bs_capture (bs_capture),
        .bs_update  (bs_update),
        .bs_reset   (bs_reset),
        .bs_tdo     (bs_tdo),
        .cap_data   (cap_data),
        .upd_data   (upd_data),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .overrun    (overrun),
        .len_err    (len_err),
        .clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800_000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // Register content loaded at Capture-DR, given the current flag state.
    function automatic logic [63:0] cap_full(input logic [31:0] cap);
        logic [63:0] r;
        r = 64'(cap);
        if (STATUS) begin
            r[DW]   = m_ovr;
            r[DW+1] = m_len;
        end
        return r;
    endfunction

    // Register after n shifts: captured bits move down, TDI bits fill from the top.
    function automatic logic [63:0] exp_sr(input logic [63:0] capf, input logic [63:0] tdi_w, input int n);
        if (n == 0) return capf;
        return ((capf >> n) | (tdi_w << (RW - n))) & mask(RW);
    endfunction

    function automatic void m_update(input logic [63:0] sr, input int n);
        if (!m_valid) begin
            m_data  = sr[31:0];
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        m_len = (n != RW);
    endfunction

    // One TCK period; TDO is sampled just before the rising edge like a JTAG host.
    task automatic jtag_cycle(input logic cap, input logic shf, input logic tdi, output logic tdo_b);
        bs_capture = cap;
        bs_shift   = shf;
        bs_tdi     = tdi;
        repeat (6) @(negedge clk);
        tdo_b  = bs_tdo;
        bs_tck = 1'b1;
        repeat (6) @(negedge clk);
        bs_tck = 1'b0;
    endtask

    task automatic capture(input logic [31:0] cap);
        logic d;
        cap_data = cap;
        jtag_cycle(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic shift_bits(input logic [63:0] tdi_w, input int first, input int n,
                              inout logic [63:0] tdo_w);
        logic b;
        for (int k = first; k < first + n; k++) begin
            jtag_cycle(1'b0, 1'b1, tdi_w[k], b);
            tdo_w[k] = b;
        end
    endtask

    task automatic exit_cycle();
        logic d;
        jtag_cycle(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic do_update();
        bs_update = 1'b1;
        repeat (6) @(negedge clk);
        bs_update = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic set_sel(input logic v);
        repeat (8) @(negedge clk);
        bs_sel = v;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"},    64'(upd_data),  64'(m_data));
        check({tag, "_valid"},   64'(upd_valid), 64'(m_valid));
        check({tag, "_overrun"}, 64'(overrun),   64'(m_ovr));
        check({tag, "_len_err"}, 64'(len_err),   64'(m_len));
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        upd_ready = 1'b1;
        @(negedge clk);
        upd_ready = 1'b0;
        m_valid   = 1'b0;
        check({tag, "_accept_valid"}, 64'(upd_valid), 64'(m_valid));
    endtask

    task automatic clear(input string tag);
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_ovr = 1'b0;
        m_len = 1'b0;
        check({tag, "_clr_overrun"}, 64'(overrun), 64'(m_ovr));
        check({tag, "_clr_len_err"}, 64'(len_err), 64'(m_len));
    endtask

    // Capture, n shifts, exit, update; checks TDO stream and fabric outputs.
    task automatic full_scan(input string tag, input logic [31:0] cap, input logic [63:0] tdi_w, input int n);
        logic [63:0] capf;
        logic [63:0] tdo_w;
        capf  = cap_full(cap);
        tdo_w = '0;
        capture(cap);
        shift_bits(tdi_w, 0, n, tdo_w);
        exit_cycle();
        check({tag, "_tdo"}, tdo_w & mask(n), capf & mask(n));
        do_update();
        m_update(exp_sr(capf, tdi_w, n), n);
        check_outputs(tag);
    endtask

    initial begin
        logic [63:0] capf, tdi_w, tdo_w;
        logic [15:0] frozen;
        logic [31:0] cap;
        logic        b;
        int          n;

        rst = 1'b1;
        {bs_tck, bs_tdi, bs_sel, bs_shift, bs_capture, bs_update, bs_reset} = '0;
        cap_data  = '0;
        upd_ready = 1'b0;
        clr_flags = 1'b0;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_len = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tdo", 64'(bs_tdo), 64'd0);
        check_outputs("reset");
        bs_sel = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal scan.
        full_scan("nominal", 32'hDEADBEEF, {$urandom(), 32'h12345678}, RW);
        accept("nominal");

        // One short shift count.
        full_scan("short", 32'hDEADBEEF, {$urandom(), 32'h12345678}, RW - 1);
        clear("short");
        accept("short");

        // Two updates without acceptance, then a third scan reading the flags back.
        full_scan("ovr1", $urandom(), {32'h0, 32'hA5A5A5A5}, RW);
        full_scan("ovr2", $urandom(), {32'h0, 32'h0F0F0F0F}, RW);
        full_scan("ovr3", $urandom(), {$urandom(), $urandom()}, RW);
        accept("ovr");
        clear("ovr");

        // SEL low freezes the register, counter and TDO; an update is ignored.
        cap   = $urandom();
        tdi_w = {$urandom(), $urandom()};
        capf  = cap_full(cap);
        tdo_w = '0;
        capture(cap);
        shift_bits(tdi_w, 0, 8, tdo_w);
        set_sel(1'b0);
        for (int k = 0; k < 16; k++) begin
            jtag_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), b);
            frozen[k] = b;
        end
        check("sel0_tdo_frozen", 64'(frozen), capf[8] ? 64'hFFFF : 64'h0);
        do_update();
        check("sel0_no_valid", 64'(upd_valid), 64'(m_valid));
        set_sel(1'b1);
        shift_bits(tdi_w, 8, RW - 8, tdo_w);
        exit_cycle();
        check("sel_tdo", tdo_w & mask(RW), capf & mask(RW));
        do_update();
        m_update(exp_sr(capf, tdi_w, RW), RW);
        check_outputs("sel");
        accept("sel");

        // System reset mid-shift discards the partial scan.
        tdo_w = '0;
        capture($urandom());
        shift_bits({$urandom(), $urandom()}, 0, 10, tdo_w);
        @(negedge clk);
        rst = 1'b1;
        bs_shift = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_len = 1'b0;
        @(negedge clk);
        check("rst_tdo", 64'(bs_tdo), 64'd0);
        check_outputs("rst");
        repeat (4) @(negedge clk);
        do_update();
        m_update(64'd0, 0);
        check_outputs("rst_upd");
        accept("rst");
        clear("rst");

        // Test-Logic-Reset clears the count but keeps the shifted contents.
        cap   = $urandom();
        tdi_w = {$urandom(), $urandom()};
        capf  = cap_full(cap);
        tdo_w = '0;
        capture(cap);
        shift_bits(tdi_w, 0, 5, tdo_w);
        bs_shift = 1'b0;
        bs_reset = 1'b1;
        repeat (8) @(negedge clk);
        bs_reset = 1'b0;
        repeat (8) @(negedge clk);
        do_update();
        m_update(exp_sr(capf, tdi_w, 5), 0);
        check_outputs("tlr");
        accept("tlr");
        clear("tlr");

        // Randomized scans with random acceptance and flag clears.
        for (int it = 0; it < 10; it++) begin
            n = ($urandom_range(0, 1) == 1) ? RW : int'($urandom_range(1, RW));
            full_scan($sformatf("rand%0d", it), $urandom(), {$urandom(), $urandom()}, n);
            if ($urandom_range(0, 2) != 0) accept($sformatf("rand%0d", it));
            if ($urandom_range(0, 3) == 0) clear($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
